// File: rtl/ring_arbiter.sv
// Round-robin ring arbiter: N requesters share one resource, each grant is
// bounded to MAXHOLD cycles and followed by at least one idle bubble.
module ring_arbiter #(
  parameter int N       = 4,
  parameter int MAXHOLD = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic [N-1:0]                   req,
  input  logic                           owner_release,
  output logic [N-1:0]                   grant,
  output logic                           grant_valid,
  output logic [N-1:0]                   ptr,
  output logic [$clog2(MAXHOLD+1)-1:0]   hold_cnt
);

  localparam int HW = $clog2(MAXHOLD + 1);
  localparam logic [N-1:0]  ONE_N     = N'(1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAXHOLD - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  ptr_q, ptr_d;
  logic          grant_valid_q, grant_valid_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;

  logic [N-1:0]  hi_req_s;
  logic [N-1:0]  pick_s;
  logic          exit_s;

  function automatic logic [N-1:0] lowest_set(input logic [N-1:0] v);
    return v & (~v + ONE_N);
  endfunction

  // Winner search: requests at or above the pointer first, else wrap to the lowest request.
  always_comb begin
    hi_req_s = req & ~(ptr_q - ONE_N);
    if (|hi_req_s) begin
      pick_s = lowest_set(hi_req_s);
    end else begin
      pick_s = lowest_set(req);
    end
  end

  // A grant ends on release, on the owner withdrawing, or when the hold budget is spent.
  always_comb begin
    exit_s = owner_release
           | ~|(req & grant_q)
           | (en & (hold_cnt_q == HOLD_LAST));
  end

  // Next-state and next-output computation for the IDLE/GRANT machine.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (en && (|req)) begin
          state_d    = GRANT;
          grant_d    = pick_s;
          hold_cnt_d = '0;
        end else begin
          state_d    = IDLE;
        end
      end
      GRANT: begin
        if (exit_s) begin
          state_d    = IDLE;
          grant_d    = '0;
          hold_cnt_d = '0;
          ptr_d      = {grant_q[N-2:0], grant_q[N-1]};
        end else if (en) begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end else begin
          hold_cnt_d = hold_cnt_q;
        end
      end
      default: begin
        state_d    = IDLE;
        grant_d    = '0;
        ptr_d      = ONE_N;
        hold_cnt_d = '0;
      end
    endcase
    grant_valid_d = |grant_d;
  end

  // State and output registers; reset takes effect without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      ptr_q         <= ONE_N;
      grant_valid_q <= 1'b0;
      hold_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      ptr_q         <= ptr_d;
      grant_valid_q <= grant_valid_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign ptr         = ptr_q;
  assign hold_cnt    = hold_cnt_q;

endmodule

// File: tb/tb_ring_arbiter.sv
// Directed self-checking bench for ring_arbiter with N=4, MAXHOLD=8.
module tb_ring_arbiter;

  logic       clk;
  logic       reset;
  logic       en;
  logic [3:0] req;
  logic       rel;
  logic [3:0] grant;
  logic       grant_valid;
  logic [3:0] ptr;
  logic [3:0] hold_cnt;

  int checks;
  int errors;

  ring_arbiter #(.N(4), .MAXHOLD(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .req           (req),
    .owner_release (rel),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .ptr           (ptr),
    .hold_cnt      (hold_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic gv,
                            input logic [3:0] p, input logic [3:0] h);
    check_value({tag, "_grant"}, 32'(grant), 32'(g));
    check_value({tag, "_gv"}, 32'(grant_valid), 32'(gv));
    check_value({tag, "_ptr"}, 32'(ptr), 32'(p));
    check_value({tag, "_hold"}, 32'(hold_cnt), 32'(h));
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  // Mid-cycle async reset pulse, checked before any rising edge arrives.
  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    #1 expect_out(tag, 4'b0000, 1'b0, 4'b0001, 4'd0);
    step();
    reset = 1'b0;
  endtask

  logic [3:0] rr_grant_exp [9];
  logic [3:0] rr_ptr_exp   [9];

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    en     = 1'b0;
    req    = 4'b0000;
    rel    = 1'b0;
    rr_grant_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                     4'b0000, 4'b1000, 4'b0000, 4'b0001};
    rr_ptr_exp   = '{4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100,
                     4'b1000, 4'b1000, 4'b0001, 4'b0001};

    #2 expect_out("reset_init", 4'b0000, 1'b0, 4'b0001, 4'd0);
    step();
    step();
    reset = 1'b0;

    // Single requester, released in its third grant cycle.
    en  = 1'b1;
    req = 4'b0100;
    step(); expect_out("single_c1", 4'b0100, 1'b1, 4'b0001, 4'd0);
    step(); expect_out("single_c2", 4'b0100, 1'b1, 4'b0001, 4'd1);
    step(); expect_out("single_c3", 4'b0100, 1'b1, 4'b0001, 4'd2);
    rel = 1'b1;
    step(); expect_out("single_end", 4'b0000, 1'b0, 4'b1000, 4'd0);
    rel = 1'b0;
    req = 4'b0000;
    step(); expect_out("single_idle", 4'b0000, 1'b0, 4'b1000, 4'd0);

    // Round robin over all four requesters, pointer wrapping 1000 -> 0001.
    do_reset("rst_rr");
    req = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      step();
      check_value("rr_grant", 32'(grant), 32'(rr_grant_exp[i]));
      check_value("rr_ptr", 32'(ptr), 32'(rr_ptr_exp[i]));
      rel = (i % 2 == 0);
    end

    // Owner withdraws its request.
    rel = 1'b0;
    req = 4'b0000;
    step(); expect_out("withdraw", 4'b0000, 1'b0, 4'b0010, 4'd0);

    // Hold timeout with a lone requester.
    req = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      step(); expect_out("timeout_hold", 4'b0001, 1'b1, 4'b0010, 4'(c));
    end
    step(); expect_out("timeout_bubble", 4'b0000, 1'b0, 4'b0010, 4'd0);
    step(); expect_out("timeout_regrant", 4'b0001, 1'b1, 4'b0010, 4'd0);
    req = 4'b0000;
    step(); expect_out("timeout_drop", 4'b0000, 1'b0, 4'b0010, 4'd0);

    // Enable gating in IDLE and during a grant.
    do_reset("rst_en");
    en  = 1'b0;
    req = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      step(); check_value("en_off_grant", 32'(grant), 32'd0);
    end
    en = 1'b1;
    step(); expect_out("en_on", 4'b0001, 1'b1, 4'b0001, 4'd0);
    step(); expect_out("en_cnt", 4'b0001, 1'b1, 4'b0001, 4'd1);
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(); expect_out("en_frozen", 4'b0001, 1'b1, 4'b0001, 4'd1);
    end
    en = 1'b1;
    step(); expect_out("en_resume", 4'b0001, 1'b1, 4'b0001, 4'd2);

    // Reset mid-grant: outputs clear immediately, inputs ignored while held.
    #2 reset = 1'b1;
    #1 expect_out("rst_mid", 4'b0000, 1'b0, 4'b0001, 4'd0);
    step(); expect_out("rst_held", 4'b0000, 1'b0, 4'b0001, 4'd0);
    reset = 1'b0;
    step(); expect_out("rst_first", 4'b0001, 1'b1, 4'b0001, 4'd0);

    // Release coinciding with hold expiry gives a single exit.
    for (int c = 1; c < 8; c++) begin
      step(); check_value("combo_hold", 32'(hold_cnt), 32'(c));
    end
    rel = 1'b1;
    step(); expect_out("combo_exit", 4'b0000, 1'b0, 4'b0010, 4'd0);
    rel = 1'b0;
    step(); expect_out("combo_next", 4'b0010, 1'b1, 4'b0010, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ring_arbiter.md
RING_ARBITER -- requirements
Module: ring_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, the number of requesters sharing one resource (N >= 2).
REQ-002 The block SHALL have parameter MAXHOLD, default 8, the maximum number of cycles one grant may be held (MAXHOLD >= 1).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit, arbitration enable.
REQ-006 The block SHALL have port req, input, N bits, request lines; bit i is requester i.
REQ-007 The block SHALL have port release, input, 1 bit, the current owner finishing its resource use.
REQ-008 The block SHALL have port grant, output, N bits, one-hot grant, or all-zero when nobody owns the resource.
REQ-009 The block SHALL have port grant_valid, output, 1 bit, equal to the OR of grant.
REQ-010 The block SHALL have port ptr, output, N bits, one-hot ring pointer marking the highest-priority requester.
REQ-011 The block SHALL have port hold_cnt, output, ceil(log2(MAXHOLD+1)) bits, cycles elapsed in the current grant.

Function
REQ-012 The block SHALL implement a two-state FSM, IDLE (grant = 0) and GRANT (grant one-hot); all outputs SHALL be registered.
REQ-013 In IDLE with en = 1 and req != 0, the next edge SHALL enter GRANT and set grant to the first asserted req bit found scanning from ptr's position upward, wrapping from bit N-1 to bit 0; hold_cnt SHALL be cleared to 0.
REQ-014 In IDLE with en = 0 or req = 0, the state SHALL remain IDLE and grant, ptr and hold_cnt SHALL hold their values.
REQ-015 Latency SHALL be exactly one edge from a sampled qualifying request to grant being visible.
REQ-016 In GRANT, the block SHALL leave GRANT on the next edge when any one of these holds: release = 1; the req bit of the owner = 0; or hold_cnt = MAXHOLD-1 with en = 1.
REQ-017 On leaving GRANT, grant SHALL become 0, the state SHALL become IDLE, hold_cnt SHALL become 0, and ptr SHALL become the old grant rotated left by one, so bit N-1 wraps to bit 0.
REQ-018 Otherwise in GRANT, grant SHALL hold, and hold_cnt SHALL increment by 1 when en = 1 and hold when en = 0.
REQ-019 Deasserting en during GRANT SHALL NOT revoke a grant; release and req-drop SHALL still end the grant.
REQ-020 Between two consecutive grants there SHALL be at least one cycle with grant = 0, giving a bubble for resource hand-off.
REQ-021 grant SHALL never have more than one bit set; ptr SHALL always have exactly one bit set.
REQ-022 The block SHALL ignore req bits of non-owners while in GRANT.
REQ-023 If release and hold expiry occur in the same cycle, the block SHALL perform a single exit with the same result as REQ-017.

Reset
REQ-024 While reset = 1, the block SHALL immediately, without waiting for clk, force state = IDLE, grant = 0, grant_valid = 0, ptr = one-hot bit 0, and hold_cnt = 0.
REQ-025 A reset asserted mid-grant SHALL drop grant in the same cycle; the first grant after reset release SHALL follow REQ-013 using ptr = bit 0.
REQ-026 The block SHALL ignore en, req and release while reset = 1.

Verification (N=4, MAXHOLD=8)
REQ-027 Reset check: assert reset asynchronously -> grant=0000, grant_valid=0, ptr=0001, hold_cnt=0 before the next clk edge.
REQ-028 Single request: en=1, req=0100, release pulsed in the 3rd grant cycle -> grant=0100 one edge after req, held 3 cycles, then 0000, and ptr=1000.
REQ-029 Round-robin with wrap: req=1111 held, release pulsed on each grant's first cycle -> grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001; ptr wraps 1000->0001.
REQ-030 Hold timeout: req=0001 held, release=0 -> grant=0001 for exactly 8 cycles with hold_cnt 0..7, then one 0000 cycle with ptr=0010, then grant=0001 again.
REQ-031 Enable gating: en=0, req=1111 for 10 cycles -> grant stays 0000; set en=1 -> grant=0001 on the next edge. Then set en=0 during the grant -> grant held and hold_cnt frozen.
REQ-032 Requester withdrawal and mid-op reset: owner drops its req bit -> grant=0000 on the next edge with ptr rotated. Then assert reset during a grant -> grant=0000 immediately and ptr=0001.
